// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous-read SRAM between two requesters: zero-fills it after
// reset or clear, then grants one access per cycle round-robin and steers read data back.
module sram_arbiter #(
  parameter  int XLEN      = 32,
  parameter  int N_ENTRIES = 1024,
  localparam int AW        = $clog2(N_ENTRIES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  output logic            init_done_o,
  input  logic            p0_req_i,
  input  logic            p0_we_i,
  input  logic [AW-1:0]   p0_addr_i,
  input  logic [XLEN-1:0] p0_data_i,
  output logic            p0_gnt_o,
  output logic            p0_rvalid_o,
  output logic [XLEN-1:0] p0_rdata_o,
  input  logic            p1_req_i,
  input  logic            p1_we_i,
  input  logic [AW-1:0]   p1_addr_i,
  input  logic [XLEN-1:0] p1_data_i,
  output logic            p1_gnt_o,
  output logic            p1_rvalid_o,
  output logic [XLEN-1:0] p1_rdata_o,
  output logic            sram_en_o,
  output logic            sram_we_o,
  output logic [AW-1:0]   sram_addr_o,
  output logic [XLEN-1:0] sram_data_o,
  input  logic [XLEN-1:0] sram_data_i
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic            last_reg, last_next;
  logic            pend_reg, pend_next;
  logic            pend_port_reg;
  logic            cnt_last;

  logic [1:0]      req_vec;
  logic [1:0]      we_vec;
  logic [AW-1:0]   addr_vec [2];
  logic [XLEN-1:0] data_vec [2];
  logic [1:0]      gnt_vec;
  logic [1:0]      rvalid_vec;
  logic [XLEN-1:0] rdata_vec [2];
  logic            win;

  assign req_vec     = {p1_req_i, p0_req_i};
  assign we_vec      = {p1_we_i, p0_we_i};
  assign addr_vec[0] = p0_addr_i;
  assign addr_vec[1] = p1_addr_i;
  assign data_vec[0] = p0_data_i;
  assign data_vec[1] = p1_data_i;

  assign cnt_last = (cnt_reg == AW'(N_ENTRIES - 1));
  assign win      = gnt_vec[1];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: if (!clear_i && cnt_last) state_next = ST_RUN;
      ST_RUN:  if (clear_i)              state_next = ST_INIT;
      default: state_next = ST_INIT;
    endcase
  end

  // Output logic; everything is forced low while reset is held
  always_comb begin
    gnt_vec     = 2'b00;
    sram_en_o   = 1'b0;
    sram_we_o   = 1'b0;
    sram_addr_o = '0;
    sram_data_o = '0;
    init_done_o = 1'b0;
    if (!rst_i) begin
      case (state_reg)
        ST_INIT: begin
          sram_en_o   = 1'b1;
          sram_we_o   = 1'b1;
          sram_addr_o = cnt_reg;
        end
        ST_RUN: begin
          init_done_o = 1'b1;
          if (!clear_i) begin
            // On a tie the port that did not win last time goes first
            gnt_vec[0] = req_vec[0] & (~req_vec[1] | last_reg);
            gnt_vec[1] = req_vec[1] & (~req_vec[0] | ~last_reg);
          end
          if (|gnt_vec) begin
            sram_en_o   = 1'b1;
            sram_we_o   = we_vec[win];
            sram_addr_o = addr_vec[win];
            sram_data_o = data_vec[win];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_next  = '0;
    last_next = last_reg;
    pend_next = 1'b0;
    if (state_reg == ST_INIT && !clear_i && !cnt_last) cnt_next = cnt_reg + AW'(1);
    if (|gnt_vec) begin
      last_next = win;
      pend_next = ~we_vec[win];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg       <= '0;
      last_reg      <= 1'b1;
      pend_reg      <= 1'b0;
      pend_port_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      last_reg      <= last_next;
      pend_reg      <= pend_next;
      pend_port_reg <= win;
    end
  end

  // A pending read completes regardless of a clear arriving in the meantime
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rvalid_vec[gi] = ~rst_i & pend_reg & (pend_port_reg == 1'(gi));
      assign rdata_vec[gi]  = rst_i ? '0 : sram_data_i;
    end
  endgenerate

  assign p0_gnt_o    = gnt_vec[0];
  assign p1_gnt_o    = gnt_vec[1];
  assign p0_rvalid_o = rvalid_vec[0];
  assign p1_rvalid_o = rvalid_vec[1];
  assign p0_rdata_o  = rdata_vec[0];
  assign p1_rdata_o  = rdata_vec[1];

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, cycle model of the arbiter and a read-response scoreboard.
module tb_sram_arbiter;
  localparam int XLEN = 32;
  localparam int N    = 16;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            rst, clear, init_done;
  logic            p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [AW-1:0]   p0_addr;
  logic [XLEN-1:0] p0_data, p0_rdata;
  logic            p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [AW-1:0]   p1_addr;
  logic [XLEN-1:0] p1_data, p1_rdata;
  logic            sram_en, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [XLEN-1:0] sram_wdata, sram_q;

  always #5 clk = ~clk;

  sram_arbiter #(.XLEN(XLEN), .N_ENTRIES(N)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .init_done_o(init_done),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_data_i(p0_data),
    .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_data_i(p1_data),
    .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_data_o(sram_wdata), .sram_data_i(sram_q)
  );

  // Storage instance: single port, registered read
  logic [XLEN-1:0] sram_mem [N];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_q <= sram_mem[sram_addr];
    end
  end

  typedef struct {
    logic            port;
    logic [XLEN-1:0] data;
  } rsp_t;
  rsp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic            m_run, m_last, m_pend, m_pport;
  int              m_cnt;
  logic [XLEN-1:0] ref_mem [N];
  logic            e_g0, e_g1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model
  task automatic step();
    logic            e_en, e_we, e_done;
    logic [AW-1:0]   e_addr;
    logic [XLEN-1:0] e_data;
    rsp_t            r;
    @(negedge clk);
    e_g0 = 0; e_g1 = 0; e_en = 0; e_we = 0; e_addr = '0; e_data = '0; e_done = 0;
    if (!rst) begin
      e_done = m_run;
      if (!m_run) begin
        e_en = 1; e_we = 1; e_addr = AW'(m_cnt);
      end else if (!clear) begin
        if (p0_req && p1_req) begin
          e_g0 = m_last; e_g1 = !m_last;
        end else begin
          e_g0 = p0_req; e_g1 = p1_req;
        end
        if (e_g0) begin e_en = 1; e_we = p0_we; e_addr = p0_addr; e_data = p0_data; end
        if (e_g1) begin e_en = 1; e_we = p1_we; e_addr = p1_addr; e_data = p1_data; end
      end
    end
    check("p0_gnt", 64'(p0_gnt), 64'(e_g0));
    check("p1_gnt", 64'(p1_gnt), 64'(e_g1));
    check("init_done", 64'(init_done), 64'(e_done));
    check("sram_en", 64'(sram_en), 64'(e_en));
    if (rst || e_en) begin
      check("sram_we", 64'(sram_we), 64'(e_we));
      check("sram_addr", 64'(sram_addr), 64'(e_addr));
      check("sram_data", 64'(sram_wdata), 64'(e_data));
    end
    check("p0_rvalid", 64'(p0_rvalid), 64'(!rst && m_pend && !m_pport));
    check("p1_rvalid", 64'(p1_rvalid), 64'(!rst && m_pend && m_pport));
    if (rst) begin
      check("p0_rdata_rst", 64'(p0_rdata), 64'(0));
      check("p1_rdata_rst", 64'(p1_rdata), 64'(0));
    end else if (m_pend) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 64'(1), 64'(0));
      end else begin
        r = sb_q.pop_front();
        check(r.port ? "p1_rdata" : "p0_rdata", 64'(r.port ? p1_rdata : p0_rdata), 64'(r.data));
        $display("read resp port%0d data %h", r.port, r.port ? p1_rdata : p0_rdata);
      end
    end
    if (rst) begin
      m_run = 0; m_cnt = 0; m_last = 1; m_pend = 0; m_pport = 0;
      sb_q.delete();
    end else begin
      m_pend  = (e_g0 || e_g1) && !e_we;
      m_pport = e_g1;
      if (m_pend) sb_q.push_back('{port: e_g1, data: ref_mem[e_addr]});
      if (e_en && e_we) ref_mem[e_addr] = e_data;
      if (e_g0 || e_g1) m_last = e_g1;
      if (!m_run) begin
        if (clear)            m_cnt = 0;
        else if (m_cnt == N-1) begin m_run = 1; m_cnt = 0; end
        else                  m_cnt++;
      end else if (clear) begin
        m_run = 0; m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; clear = 0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_data = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_data = '0;
    m_run = 0; m_cnt = 0; m_last = 1; m_pend = 0; m_pport = 0;
    for (int i = 0; i < N; i++) ref_mem[i] = '1;

    // Reset, then both ports hold reads through INIT and for four cycles after
    step(); step();
    rst = 0;
    p0_req = 1; p0_we = 0; p0_addr = 4'd5;
    p1_req = 1; p1_we = 0; p1_addr = 4'd9;
    repeat (N) step();
    repeat (4) step();
    p0_req = 0; p1_req = 0;
    step(); step();

    // Write on p1 then read-after-write on p0
    p1_req = 1; p1_we = 1; p1_addr = 4'd3; p1_data = 32'hDEADBEEF;
    step();
    p1_req = 0; p0_req = 1; p0_we = 0; p0_addr = 4'd3;
    step();
    p0_req = 0;
    step();

    // Read on p1 followed by clear; the read still returns, then a full re-sweep
    p1_req = 1; p1_we = 0; p1_addr = 4'd3;
    step();
    p1_req = 0; clear = 1;
    step();
    clear = 0;
    repeat (N) step();
    p0_req = 1; p0_we = 0; p0_addr = 4'd3;
    step();
    p0_req = 0;
    step();

    // Reset in the middle of a sweep
    clear = 1;
    step();
    clear = 0;
    repeat (7) step();
    rst = 1;
    step();
    rst = 0;
    repeat (N + 1) step();

    // Random traffic; a requester holds its request until granted
    for (int k = 0; k < 80; k++) begin
      if (!p0_req) begin
        p0_req = 1'($urandom_range(0, 1)); p0_we = 1'($urandom_range(0, 1));
        p0_addr = AW'($urandom_range(0, N-1)); p0_data = $urandom;
      end
      if (!p1_req) begin
        p1_req = 1'($urandom_range(0, 1)); p1_we = 1'($urandom_range(0, 1));
        p1_addr = AW'($urandom_range(0, N-1)); p1_data = $urandom;
      end
      step();
      if (e_g0) p0_req = 0;
      if (e_g1) p1_req = 0;
    end
    p0_req = 0; p1_req = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
